// File: rtl/reg_alu_sequencer.sv
// Instruction queue plus execute/readback sequencer for reg_alu_top.
// Issues one ALU word, reads Rd back in two 16-bit halves, returns {rd, result}.
module reg_alu_sequencer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic [15:0] inst_data,
  output logic [2:0]  ALU_Operation,
  output logic [3:0]  Rs,
  output logic [3:0]  Rt,
  output logic [3:0]  Rd,
  output logic        execute,
  output logic        DFT_Display_Select,
  input  logic [15:0] display_output,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [31:0] result,
  output logic [3:0]  result_rd,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    IDLE, ISSUE1, ISSUE2, SETTLE, RD_LO, RD_HI, RESP
  } state_t;

  state_t          state;
  logic [15:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic [15:0]     head;
  logic            unused_bit;

  assign full       = (count == CW'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign inst_ready = !full;
  assign push       = inst_valid && !full;
  assign head       = mem[rd_ptr];
  assign unused_bit = head[12];
  assign busy       = (state != IDLE) || !empty;

  // The FSM consumes the head word when it can start a new issue.
  assign pop = !empty &&
               ((state == IDLE) || (state == RESP && result_ready));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= inst_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= IDLE;
      ALU_Operation      <= '0;
      Rs                 <= '0;
      Rt                 <= '0;
      Rd                 <= '0;
      execute            <= 1'b0;
      DFT_Display_Select <= 1'b0;
      result_valid       <= 1'b0;
      result             <= '0;
      result_rd          <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            ALU_Operation <= head[15:13];
            Rs            <= head[11:8];
            Rt            <= head[7:4];
            Rd            <= head[3:0];
            execute       <= 1'b1;
            state         <= ISSUE1;
          end
        end
        ISSUE1: state <= ISSUE2;
        ISSUE2: begin
          execute            <= 1'b0;
          DFT_Display_Select <= 1'b0;
          state              <= SETTLE;
        end
        SETTLE: state <= RD_LO;
        RD_LO: begin
          result[15:0]       <= display_output;
          result_rd          <= Rd;
          DFT_Display_Select <= 1'b1;
          state              <= RD_HI;
        end
        RD_HI: begin
          result[31:16] <= display_output;
          result_valid  <= 1'b1;
          state         <= RESP;
        end
        RESP: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            if (pop) begin
              ALU_Operation <= head[15:13];
              Rs            <= head[11:8];
              Rt            <= head[7:4];
              Rd            <= head[3:0];
              execute       <= 1'b1;
              state         <= ISSUE1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_alu_sequencer.sv
// Bench for reg_alu_sequencer with a behavioural reg_alu_top register bank.
// Stimulus pushes expected {rd, result}; a negedge monitor pops and compares.
module tb_reg_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inst_valid = 1'b0;
  logic        inst_ready;
  logic [15:0] inst_data = '0;
  logic [2:0]  ALU_Operation;
  logic [3:0]  Rs, Rt, Rd;
  logic        execute;
  logic        DFT_Display_Select;
  logic [15:0] display_output;
  logic        result_valid;
  logic        result_ready = 1'b1;
  logic [31:0] result;
  logic [3:0]  result_rd;
  logic        busy;

  reg_alu_sequencer #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data),
    .ALU_Operation(ALU_Operation), .Rs(Rs), .Rt(Rt), .Rd(Rd),
    .execute(execute), .DFT_Display_Select(DFT_Display_Select),
    .display_output(display_output),
    .result_valid(result_valid), .result_ready(result_ready),
    .result(result), .result_rd(result_rd), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register bank model: Rn=n at start, one write per execute pulse.
  logic [31:0] rf [16];
  logic        exec_d = 1'b0;
  always @(posedge clk) begin
    exec_d <= execute;
    if (cyc == 0) begin
      for (int i = 0; i < 16; i++) rf[i] <= 32'(i);
    end else if (execute && !exec_d) begin
      case (ALU_Operation)
        3'd0: rf[Rd] <= rf[Rs] + rf[Rt];
        3'd1: rf[Rd] <= rf[Rs] - rf[Rt];
        3'd2: rf[Rd] <= rf[Rs] & rf[Rt];
        3'd3: rf[Rd] <= rf[Rs] | rf[Rt];
        3'd4: rf[Rd] <= rf[Rs] ^ rf[Rt];
        default: rf[Rd] <= '0;
      endcase
    end
  end
  assign display_output = DFT_Display_Select ? rf[Rd][31:16] : rf[Rd][15:0];

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [35:0] act,
                     input logic [35:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  logic [35:0] sb [$];
  int          rise_t [$];
  int          exec_rises = 0;
  int          exec_run = 0;
  logic        pv = 1'b0, pr = 1'b0, psel = 1'b0, pexec = 1'b0;
  logic [35:0] pres = '0;

  always @(negedge clk) begin
    if (rst) begin
      if (result_valid && !pv) begin
        rise_t.push_back(cyc);
        chk("sel_hi_capture", 36'(psel), 36'(1));
      end
      if (pv && result_valid && !pr)
        chk("result_stable", {result_rd, result}, pres);
      if (result_valid && result_ready) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_result: got %h want none",
                   {result_rd, result});
        end else begin
          chk("result", {result_rd, result}, sb.pop_front());
        end
      end
      if (execute) exec_run++;
      else if (exec_run != 0) begin
        chk("exec_width", 36'(exec_run), 36'(2));
        exec_run = 0;
      end
      if (execute && !pexec) exec_rises++;
      pv    = result_valid;
      pr    = result_ready;
      psel  = DFT_Display_Select;
      pexec = execute;
      pres  = {result_rd, result};
    end else begin
      pv       = 1'b0;
      pr       = 1'b0;
      pexec    = 1'b0;
      exec_run = 0;
    end
  end

  task automatic push(input logic [15:0] w, input logic [35:0] exp,
                      input bit expect_it, output int t);
    bit done = 1'b0;
    inst_data  = w;
    inst_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (inst_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    inst_valid = 1'b0;
    t = cyc;
    if (done && expect_it) sb.push_back(exp);
    if (!done) begin
      checks++;
      $display("FAIL push_timeout: word %h not accepted, want accepted", w);
    end
  endtask

  task automatic wait_drain(input int budget);
    int i = 0;
    while (sb.size() != 0 && i < budget) begin
      @(posedge clk);
      i++;
    end
    #1;
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout: pending %0d want 0", sb.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang want finish");
    $fatal(1);
  end

  initial begin
    int t0, r, base, nr;
    logic [15:0] bp_w [6];
    logic [35:0] bp_e [6];
    bp_w = '{16'h045A, 16'h067B, 16'h282C, 16'h643D, 16'h875F, 16'h4F62};
    bp_e = '{{4'd10, 32'd9}, {4'd11, 32'd13}, {4'd12, 32'd6},
             {4'd13, 32'd7}, {4'd15, 32'd2}, {4'd2, 32'd2}};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_inst_ready", 36'(inst_ready), 36'(1));
    chk("rst_ctrl", 36'({execute, result_valid, busy, DFT_Display_Select}),
        36'(0));
    chk("rst_regs", 36'({ALU_Operation, Rs, Rt, Rd}), 36'(0));
    chk("rst_result", {result_rd, result}, 36'(0));
    rst = 1'b1;
    @(posedge clk);
    #1;

    // ADD R2+R3 -> R14
    push(16'h023E, {4'd14, 32'h0000_0005}, 1'b1, t0);
    wait_drain(100);
    r = rise_t.size();
    if (r >= 1) chk("latency", 36'(rise_t[r-1] - t0), 36'(6));
    else chk("latency_seen", 36'(r), 36'(1));

    // SUB R1-R5 -> R9
    push(16'h2159, {4'd9, 32'hFFFF_FFFC}, 1'b1, t0);
    wait_drain(100);

    // Dependent chain: R0=R1+R2, then R1=R0+R3
    push(16'h0120, {4'd0, 32'd3}, 1'b1, t0);
    push(16'h0031, {4'd1, 32'd6}, 1'b1, t0);
    wait_drain(100);
    r = rise_t.size();
    if (r >= 2) chk("chain_spacing", 36'(rise_t[r-1] - rise_t[r-2]), 36'(6));
    else chk("chain_seen", 36'(r), 36'(2));

    // Backpressure: consumer stalls while six words arrive
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    base = exec_rises;
    for (int i = 0; i < 5; i++) push(bp_w[i], bp_e[i], 1'b1, t0);
    chk("full_blocks", 36'(inst_ready), 36'(0));
    fork
      push(bp_w[5], bp_e[5], 1'b1, t0);
      begin
        repeat (20) @(negedge clk);
        chk("no_second_execute", 36'(exec_rises - base), 36'(1));
        chk("still_full", 36'(inst_ready), 36'(0));
        chk("held_valid", 36'(result_valid), 36'(1));
        @(posedge clk);
        #1;
        result_ready = 1'b1;
      end
    join
    wait_drain(200);
    chk("drain_busy", 36'(busy), 36'(0));

    // Reset mid-issue: one word executing, one queued
    nr = rise_t.size();
    push(16'h0113, '0, 1'b0, t0);
    push(16'h0224, '0, 1'b0, t0);
    @(posedge clk);
    #2;
    chk("exec_before_rst", 36'(execute), 36'(1));
    rst = 1'b0;
    #1;
    chk("rst_exec_drop", 36'(execute), 36'(0));
    chk("rst_busy_drop", 36'(busy), 36'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_ready", 36'(inst_ready), 36'(1));
    chk("post_rst_idle", 36'({busy, execute, result_valid}), 36'(0));
    chk("no_stale_result", 36'(rise_t.size() - nr), 36'(0));
    chk("scoreboard_empty", 36'(sb.size()), 36'(0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/reg_alu_sequencer.md
# reg_alu_sequencer

Initiator-side controller for `reg_alu_top`. It accepts 16-bit ALU instruction words through a valid/ready queue and drives `ALU_Operation`/`Rs`/`Rt`/`Rd`/`execute` with the register-bank execute protocol. It then reads the 32-bit destination value back over the 16-bit `display_output` port using `DFT_Display_Select`, and returns `{rd, result}` on a valid/ready result port. It sits between the instruction source (switch/UART front-end or bench) and `reg_alu_top`.

## Interface
- `FIFO_DEPTH`, 4: instruction queue depth; power of two, ≥2.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous, active-low. Clears the FSM, queue and outputs. It is independent of `reg_alu_top`'s own reset.
- `inst_valid`  in  1  instruction word present.
- `inst_ready`  out  1  queue can accept a word; equals `!full`.
- `inst_data`  in  16  instruction word: [15:13] op, [12] ignored, [11:8] rs, [7:4] rt, [3:0] rd.
- `ALU_Operation`  out  3  op to `reg_alu_top`.
- `Rs`, `Rt`, `Rd`  out  4 each  register addresses to `reg_alu_top`.
- `execute`  out  1  write strobe to `reg_alu_top`.
- `DFT_Display_Select`  out  1  0 selects result[15:0], 1 selects result[31:16].
- `display_output`  in  16  readback from `reg_alu_top`; combinational on `DFT_Display_Select`.
- `result_valid`  out  1  result held for the consumer.
- `result_ready`  in  1  consumer accepts the result.
- `result`  out  32  value read back from Rd.
- `result_rd`  out  4  destination address of `result`.
- `busy`  out  1  FSM not in IDLE, or queue non-empty.

## Operation
- Queue: synchronous FIFO of `FIFO_DEPTH` words.
  - A push happens when `inst_valid && inst_ready`.
  - A pop is performed by the FSM.
  - Simultaneous push and pop leave the count unchanged.
  - `full` and `empty` are derived from a registered count, which is (log2 depth)+1 bits wide.
  - Pointers wrap modulo depth.
- FSM states and transitions:
  - IDLE → ISSUE1 when the queue is non-empty. The head word is popped, and op/rs/rt/rd are registered onto the outputs.
  - ISSUE1 → ISSUE2; `execute`=1 in both states.
  - ISSUE2 → SETTLE; `execute`=0.
  - SETTLE → RD_LO; `DFT_Display_Select`=0.
  - RD_LO → RD_HI. At the RD_LO→RD_HI edge, capture `display_output` into result[15:0]. `DFT_Display_Select`=1 in RD_HI.
  - RD_HI → RESP. At this edge, capture `display_output` into result[31:16].
  - In RESP, `result_valid`=1. On `result_ready`:
    - queue non-empty → pop the next word and go to ISSUE1 directly;
    - otherwise → IDLE.
- `ALU_Operation`/`Rs`/`Rt`/`Rd` change only on entry to ISSUE1. They are held stable through RESP and afterwards.
- `result`/`result_rd` change only at RD_LO/RD_HI capture. They are stable while `result_valid`=1.
- No new `execute` pulse is issued while a result is unaccepted (backpressure).
- Reset values: all outputs 0 except `inst_ready`=1. State is IDLE and the queue is empty.
- Reset asserted mid-operation:
  - `execute`, `result_valid` and `busy` drop immediately (asynchronously);
  - queued words are discarded;
  - a partially captured result is lost.

## Timing
- A word accepted at edge E0 into an empty queue with the FSM in IDLE:
  - ISSUE1 from E1, so `execute` is high from E1 to E3 (exactly 2 cycles);
  - SETTLE from E3 to E4;
  - lo half captured at E5, hi half captured at E6;
  - `result_valid` high from E6.
- Accept-to-result latency is 6 cycles.
- With `result_ready` held at 1 and the queue non-empty, one instruction completes every 6 cycles. `execute` is low for ≥4 cycles between pulses.
- `inst_ready` reflects the registered count. A push and a pop in the same cycle on a full queue is impossible, because the push is blocked.

## Test plan
- Reset `reg_alu_top` so Rn=n. Push `0x023E` (ADD R2+R3→R14). Required: `execute` high exactly 2 cycles; `result_valid` at E6 with `result`=0x00000005 and `result_rd`=14.
- Push `0x2159` (SUB R1−R5→R9). Required: `result`=0xFFFFFFFC, `result_rd`=9. The hi half shows `DFT_Display_Select`=1 during the capture cycle.
- Chain `0x0120` then `0x0031` back-to-back (ADD R1+R2→R0, then ADD R0+R3→R1). Required: results 3 then 6, in order, with 6-cycle spacing while `result_ready`=1.
- Push 6 words with `result_ready`=0. Required:
  - the first is issued;
  - `inst_ready` drops after 4 are queued;
  - no second `execute` pulse occurs;
  - `result` stays stable.
  - Releasing `result_ready` then drains all words in order.
- Assert `rst`=0 during ISSUE2. Required: `execute`=0 and `busy`=0 immediately; after release, no result appears and `inst_ready`=1.
